cnt_reg_bank: RTL
=================

Name: cnt_reg_bank

Overview:
Parametrised host register bank for the multi-channel counter array. It generalises the single-channel 8-bit/32-bit counter register file to N8 8-bit and N32 32-bit channels, packed per-channel control bits and packed load values. It adds new behaviour: self-clearing load strobes, a registered read path with a valid pulse, sticky wrap-around status with write-1-to-clear, a mask, and an interrupt output. It sits between the host bus (cs/rw/addr/wdata) and the counter instances.

Parameters:
N8, 1, number of 8-bit counter channels (legal 1..16)
N32, 1, number of 32-bit counter channels (legal 1..16)

Ports:
clk  in  1  clock, all state on rising edge
xrst  in  1  asynchronous active-low reset
cs  in  1  bus select, one access per cycle when high
rw  in  1  1 = write, 0 = read
addr  in  8  word address
wdata  in  32  write data
rdata  out  32  registered read data
rvalid  out  1  one-cycle pulse, rdata valid
en8  out  N8  8-bit channel enables
ld8  out  N8  8-bit channel load strobes
val8  out  8*N8  load values, channel i at [8i+7:8i]
cnt8  in  8*N8  8-bit counts, channel i at [8i+7:8i]
en32  out  N32  32-bit channel enables
cnt32  in  32*N32  32-bit counts, channel j at [32j+31:32j]
irq  out  1  interrupt, registered

Behaviour:
- Clock and reset: one clock, clk. Reset xrst is asynchronous and active-low. Reset clears every register and output to 0: en8, ld8, val8, en32, rdata, rvalid, irq, status, mask, and the internal sample registers.
- Write strobe: cs & rw. Read strobe: cs & ~rw.
- Register map:
  - 0x00 EN8, RW, bits [N8-1:0].
  - 0x01 LD8, write-only strobe; reads as 0.
  - 0x02 EN32, RW, bits [N32-1:0].
  - 0x04..0x07 VAL8 word k, RW. Byte b holds channel 4k+b. Bytes for channels >= N8 are not stored and read as 0.
  - 0x08 STATUS, RO/W1C. Bit i (i<N8) = 8-bit channel i wrapped. Bit 16+j (j<N32) = 32-bit channel j wrapped.
  - 0x09 MASK, RW, same bit layout as STATUS.
  - 0x10+i CNT8 channel i, RO, zero-extended.
  - 0x20+j CNT32 channel j, RO.
- Unimplemented bits and addresses: write ignored, read returns 0.
- Writes to RW registers take effect on the edge where the write strobe is sampled. The output is visible the following cycle.
- LD8 strobe: a write to 0x01 with wdata[i]=1 drives ld8[i]=1 for exactly one cycle, the cycle after the write. ld8 then returns to 0 with no host action. Back-to-back writes give back-to-back pulses.
- Read path:
  - rdata and rvalid register on the edge that samples the read strobe, so latency is 1 cycle.
  - rvalid is high for exactly that one cycle.
  - rdata holds its value until the next read.
  - Writes do not disturb rdata.
- Wrap detection:
  - Per channel, keep last-cycle samples of cnt and of en, plus ld for 8-bit channels.
  - The wrap event fires when prev_cnt == all-ones, cur_cnt == 0, prev_en == 1, and (8-bit only) prev_ld == 0.
  - On a wrap event the STATUS bit is set.
  - A load to 0 therefore does not flag.
- STATUS clear: a write to 0x08 clears the bits where wdata=1. If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq: registered |(STATUS & MASK), so it lags a STATUS or MASK change by 1 cycle.
- Reset mid-operation: a pending ld8 pulse, rvalid, and sticky status are all lost. The first sampled cycle after reset cannot flag a wrap, because prev_en = 0.

Test Plan:
- Reset then read 0x00, 0x02, 0x08, 0x09 -> rvalid one cycle after each read, rdata = 0. Outputs are all 0 from reset assertion onward.
- N8=5: write 0x00 = 0x1F, write 0x05 = 0xAB -> en8 = 5'h1F, val8[39:32] = 8'hAB. Read 0x05 -> 0x000000AB (bytes 1..3 are 0).
- Write 0x01 = 0x3 -> ld8 = 2'b11 for exactly one cycle, then 0. Read 0x01 -> 0.
- Drive cnt8[7:0] from 0xFF to 0x00 with en8[0]=1 -> STATUS bit0 = 1. With MASK = 1, irq rises 1 cycle later. Repeat the same transition with ld8[0] pulsed -> no flag.
- Write STATUS = 0x1 in the same cycle a new channel-0 wrap is detected -> bit0 remains 1. Next, W1C alone -> bit0 = 0 and irq drops 1 cycle later.
- Drive cnt32 channel 1 = 0xDEADBEEF, read 0x21 -> rdata = 0xDEADBEEF with a 1-cycle rvalid. Read 0x3F -> 0. Write 0x3F -> no state change.

Source files
------------

// File: rtl/cnt_reg_bank.sv
// Host register bank for the multi-channel counter array: enables, load strobes,
// load values, sticky wrap status with mask and interrupt, and a registered read port.
module cnt_reg_bank #(
   parameter int N8  = 1,
   parameter int N32 = 1
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              cs,
   input  logic              rw,
   input  logic [7:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic [N8-1:0]     en8,
   output logic [N8-1:0]     ld8,
   output logic [8*N8-1:0]   val8,
   input  logic [8*N8-1:0]   cnt8,
   output logic [N32-1:0]    en32,
   input  logic [32*N32-1:0] cnt32,
   output logic              irq
);

   localparam logic [15:0] M8        = 16'((32'd1 << N8) - 32'd1);
   localparam logic [15:0] M32       = 16'((32'd1 << N32) - 32'd1);
   localparam logic [31:0] STAT_BITS = {M32, M8};

   logic              wr;
   logic              rd;
   logic [31:0]       status;
   logic [31:0]       mask;
   logic [31:0]       wrap;
   logic [31:0]       rd_data;
   logic [8*N8-1:0]   prev_cnt8;
   logic [N8-1:0]     prev_en8;
   logic [N8-1:0]     prev_ld8;
   logic [32*N32-1:0] prev_cnt32;
   logic [N32-1:0]    prev_en32;

   assign wr = cs & rw;
   assign rd = cs & ~rw;

   // A wrap is all-ones to zero while enabled; a load that lands on zero is excluded.
   always_comb begin
      wrap = '0;
      for (int i = 0; i < N8; i++)
         wrap[i] = (prev_cnt8[8*i +: 8] == 8'hFF) && (cnt8[8*i +: 8] == 8'h00) &&
                   prev_en8[i] && !prev_ld8[i];
      for (int j = 0; j < N32; j++)
         wrap[16+j] = (prev_cnt32[32*j +: 32] == 32'hFFFF_FFFF) &&
                      (cnt32[32*j +: 32] == 32'h0) && prev_en32[j];
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         8'h00: rd_data[N8-1:0]  = en8;
         8'h02: rd_data[N32-1:0] = en32;
         8'h04, 8'h05, 8'h06, 8'h07: begin
            for (int c = 0; c < N8; c++)
               if (addr == 8'(4 + c/4)) rd_data[8*(c%4) +: 8] = val8[8*c +: 8];
         end
         8'h08: rd_data = status;
         8'h09: rd_data = mask;
         default: begin
            for (int i = 0; i < N8; i++)
               if (addr == 8'(16 + i)) rd_data = {24'h0, cnt8[8*i +: 8]};
            for (int j = 0; j < N32; j++)
               if (addr == 8'(32 + j)) rd_data = cnt32[32*j +: 32];
         end
      endcase
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         en8        <= '0;
         ld8        <= '0;
         val8       <= '0;
         en32       <= '0;
         mask       <= '0;
         status     <= '0;
         irq        <= 1'b0;
         rdata      <= '0;
         rvalid     <= 1'b0;
         prev_cnt8  <= '0;
         prev_en8   <= '0;
         prev_ld8   <= '0;
         prev_cnt32 <= '0;
         prev_en32  <= '0;
      end else begin
         prev_cnt8  <= cnt8;
         prev_en8   <= en8;
         prev_ld8   <= ld8;
         prev_cnt32 <= cnt32;
         prev_en32  <= en32;
         rvalid     <= rd;
         if (rd) rdata <= rd_data;
         ld8 <= (wr && addr == 8'h01) ? wdata[N8-1:0] : '0;
         if (wr) begin
            case (addr)
               8'h00:   en8  <= wdata[N8-1:0];
               8'h02:   en32 <= wdata[N32-1:0];
               8'h09:   mask <= wdata & STAT_BITS;
               default: ;
            endcase
         end
         for (int c = 0; c < N8; c++)
            if (wr && addr == 8'(4 + c/4)) val8[8*c +: 8] <= wdata[8*(c%4) +: 8];
         // Set is applied after the clear so a simultaneous wrap keeps the bit.
         status <= (status & ~((wr && addr == 8'h08) ? wdata : 32'h0)) | wrap;
         irq    <= |(status & mask);
      end
   end

endmodule
